// File: rtl/pe_abuf_drain.sv
// Accumulation-buffer drain: sweeps an address range through the PE read port, rescales each
// lane (rounding arithmetic shift + signed saturation) and streams beats out under credit control.
module pe_abuf_drain #(
  parameter int BATCH     = 8,
  parameter int RES_W     = 32,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int RD_LAT    = 2,
  parameter int FIFO_D    = RD_LAT + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           len,
  input  logic [4:0]                shift,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         abuf_rd_addr,
  input  logic [BATCH*RES_W-1:0]    abuf_rd_data,
  output logic [BATCH*DATA_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
);

  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_D);
  localparam logic signed [RES_W:0] SAT_MAX = $signed({{(RES_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [RES_W:0] SAT_MIN = $signed({{(RES_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2} state_e;

  // Round-half-up arithmetic shift, widened by one bit so the rounding add cannot wrap.
  function automatic logic [DATA_W-1:0] rescale(input logic [RES_W-1:0] x, input logic [4:0] sh);
    logic signed [RES_W:0] xe;
    logic signed [RES_W:0] t;
    logic                  rb;
    xe = $signed({x[RES_W-1], x});
    rb = (sh != 5'd0) ? x[sh - 5'd1] : 1'b0;
    t  = (xe >>> sh) + $signed({{RES_W{1'b0}}, rb});
    if (t > SAT_MAX) begin
      rescale = SAT_MAX[DATA_W-1:0];
    end else if (t < SAT_MIN) begin
      rescale = SAT_MIN[DATA_W-1:0];
    end else begin
      rescale = t[DATA_W-1:0];
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W:0]           rem_q, rem_d;
  logic [4:0]                shift_q, shift_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]             credit_q, credit_d;
  logic                      issue_s, last_issue_s, pop_s, drained_s;
  logic [RD_LAT-1:0]         vld_q, lst_q;
  logic                      rs_vld_q, rs_last_q;
  logic [BATCH*DATA_W-1:0]   rs_data_q, rs_data_d;
  logic [BATCH*DATA_W-1:0]   mem_data [FIFO_D];
  logic                      mem_last [FIFO_D];
  logic [PW-1:0]             rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]             mem_cnt_q, mem_cnt_d;
  logic                      mem_rd_s, mem_wr_s;
  logic                      ov_q, ov_d, ol_q, ol_d;
  logic [BATCH*DATA_W-1:0]   od_q, od_d;

  assign pop_s     = ov_q & out_ready;
  assign drained_s = (credit_q + {{(CW-1){1'b0}}, pop_s}) == CRED_MAX;

  // Job sequencing: launch, address issue under credit, and drain-wait before done.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    shift_d      = shift_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d = READ;
          addr_d  = base_addr;
          rem_d   = len;
          shift_d = shift;
          busy_d  = 1'b1;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (credit_q != '0) begin
          issue_s = 1'b1;
          addr_d  = (addr_q == ADDR_W'(BUF_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            last_issue_s = 1'b1;
            state_d      = FLUSH;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      FLUSH: begin
        if (drained_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit tracks free FIFO slots not yet claimed by an issued read.
  always_comb begin
    credit_d = credit_q;
    if (issue_s && !pop_s) begin
      credit_d = credit_q - CW'(1);
    end else if (!issue_s && pop_s) begin
      credit_d = credit_q + CW'(1);
    end else begin
      credit_d = credit_q;
    end
  end

  // Output slot refills from backing storage first, otherwise directly from the rescale stage.
  always_comb begin
    mem_rd_s = 1'b0;
    mem_wr_s = 1'b0;
    ov_d     = ov_q;
    od_d     = od_q;
    ol_d     = ol_q;
    if (!ov_q || pop_s) begin
      if (mem_cnt_q != '0) begin
        mem_rd_s = 1'b1;
        mem_wr_s = rs_vld_q;
        ov_d     = 1'b1;
        od_d     = mem_data[rd_ptr_q];
        ol_d     = mem_last[rd_ptr_q];
      end else if (rs_vld_q) begin
        ov_d = 1'b1;
        od_d = rs_data_q;
        ol_d = rs_last_q;
      end else begin
        ov_d = 1'b0;
        ol_d = 1'b0;
      end
    end else begin
      mem_wr_s = rs_vld_q;
    end
    case ({mem_wr_s, mem_rd_s})
      2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Per-lane rescale of the returning read word.
  always_comb begin
    rs_data_d = '0;
    for (int i = 0; i < BATCH; i++) begin
      rs_data_d[i*DATA_W +: DATA_W] = rescale(abuf_rd_data[i*RES_W +: RES_W], shift_q);
    end
  end

  // Control, read-valid pipe, rescale register and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      credit_q  <= CRED_MAX;
      vld_q     <= '0;
      lst_q     <= '0;
      rs_vld_q  <= 1'b0;
      rs_last_q <= 1'b0;
      rs_data_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      mem_cnt_q <= '0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      ol_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      credit_q  <= credit_d;
      vld_q[0]  <= issue_s;
      lst_q[0]  <= last_issue_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      rs_vld_q  <= vld_q[RD_LAT-1];
      rs_last_q <= lst_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) begin
        rs_data_q <= rs_data_d;
      end
      if (mem_rd_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (mem_wr_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      mem_cnt_q <= mem_cnt_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      ol_q      <= ol_d;
    end
  end

  // Backing storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_data[wr_ptr_q] <= rs_data_q;
      mem_last[wr_ptr_q] <= rs_last_q;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign abuf_rd_addr = addr_q;
  assign out_data     = od_q;
  assign out_valid    = ov_q;
  assign out_last     = ol_q;

endmodule

// File: tb/tb_pe_abuf_drain.sv
// Scoreboard bench for pe_abuf_drain: a behavioural accum buffer feeds the DUT, expected beats
// are queued at job launch and compared as the DUT hands them off.
module tb_pe_abuf_drain;
  localparam int BATCH = 8, RES_W = 32, DATA_W = 16, BUF_DEPTH = 256, ADDR_W = 8;
  localparam int RD_LAT = 2, FIFO_D = 5;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W:0]         len;
  logic [4:0]              shift;
  logic                    busy, done;
  logic [ADDR_W-1:0]       abuf_rd_addr;
  logic [BATCH*RES_W-1:0]  abuf_rd_data;
  logic [BATCH*DATA_W-1:0] out_data;
  logic                    out_valid, out_ready, out_last;

  pe_abuf_drain #(.BATCH(BATCH), .RES_W(RES_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH),
                  .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len), .shift(shift),
    .busy(busy), .done(done), .abuf_rd_addr(abuf_rd_addr), .abuf_rd_data(abuf_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accum buffer model with two cycles of read latency.
  logic [BATCH*RES_W-1:0] abuf_mem [BUF_DEPTH];
  logic [BATCH*RES_W-1:0] rd_stage;
  always @(posedge clk) begin
    rd_stage     <= abuf_mem[abuf_rd_addr];
    abuf_rd_data <= rd_stage;
  end

  int checks = 0, failures = 0;
  int beats = 0, done_cnt = 0, hs_cnt = 0;
  logic [BATCH*DATA_W-1:0] exp_data_q [$];
  bit                      exp_last_q [$];

  function automatic logic [DATA_W-1:0] ref_rescale(input logic [RES_W-1:0] v, input int s);
    longint x, t;
    logic [63:0] tv;
    x = longint'($signed(v));
    if (s == 0) t = x;
    else t = (x >>> s) + ((x >>> (s - 1)) & 64'sd1);
    if (t > 64'sd32767) t = 64'sd32767;
    else if (t < -64'sd32768) t = -64'sd32768;
    tv = t;
    return tv[DATA_W-1:0];
  endfunction

  task automatic push_job(input int b, input int n, input int s);
    logic [BATCH*RES_W-1:0]  w;
    logic [BATCH*DATA_W-1:0] e;
    for (int k = 0; k < n; k++) begin
      w = abuf_mem[(b + k) % BUF_DEPTH];
      for (int i = 0; i < BATCH; i++) e[i*DATA_W +: DATA_W] = ref_rescale(w[i*RES_W +: RES_W], s);
      exp_data_q.push_back(e);
      exp_last_q.push_back(k == n - 1);
    end
  endtask

  task automatic fill_random(input int b, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < BATCH; i++) abuf_mem[(b + k) % BUF_DEPTH][i*RES_W +: RES_W] = $urandom;
  endtask

  // Launch: start is high for exactly one cycle (cycle 0); returns 1ns into cycle 1.
  task automatic launch(input int b, input int n, input int s);
    @(posedge clk); #1;
    base_addr = b[ADDR_W-1:0];
    len       = n[ADDR_W:0];
    shift     = s[4:0];
    start     = 1'b1;
    push_job(b, n, s);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // Monitor: handshakes pop the scoreboard; a stalled beat must hold still.
  logic [BATCH*DATA_W-1:0] hold_data;
  bit hold_last, holding;
  initial begin
    logic [BATCH*DATA_W-1:0] ed;
    bit el;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rst && out_valid) begin
        if (holding) begin
          checks++;
          if (out_data !== hold_data || out_last !== hold_last) begin
            failures++;
            $display("FAIL stall_stable: got %h/%b want %h/%b", out_data, out_last, hold_data, hold_last);
          end
        end
        if (out_ready) begin
          holding = 1'b0;
          hs_cnt++; beats++;
          checks++;
          if (exp_data_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat: got %h with scoreboard empty", out_data);
          end else begin
            ed = exp_data_q.pop_front();
            el = exp_last_q.pop_front();
            if (out_data !== ed || out_last !== el) begin
              failures++;
              $display("FAIL beat: got %h last=%b want %h last=%b", out_data, out_last, ed, el);
            end
          end
        end else begin
          holding = 1'b1; hold_data = out_data; hold_last = out_last;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; shift = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b done=%b valid=%b last=%b want 0000", busy, done, out_valid, out_last);
    end
    checks++;
    if (out_data !== '0 || abuf_rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_data: got data=%h addr=%h want 0", out_data, abuf_rd_addr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_base();
    int d0, b0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < BATCH; i++) abuf_mem[8'h10 + k][i*RES_W +: RES_W] = 32'(8 * k + i + 1);
    out_ready = 1'b1;
    d0 = done_cnt; b0 = beats;
    launch(8'h10, 4, 0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (abuf_rd_addr !== 8'h10) begin
          failures++; $display("FAIL base_first_addr: got %h want 10", abuf_rd_addr);
        end
      end
      checks++;
      if (out_valid !== (c >= 5 && c <= 8) || out_last !== (c == 8)) begin
        failures++;
        $display("FAIL base_valid_c%0d: got valid=%b last=%b want %b/%b", c, out_valid, out_last, (c >= 5 && c <= 8), (c == 8));
      end
      checks++;
      if (done !== (c == 9) || busy !== (c <= 8)) begin
        failures++;
        $display("FAIL base_done_c%0d: got done=%b busy=%b want %b/%b", c, done, busy, (c == 9), (c <= 8));
      end
    end
    #1;
    checks++;
    if (beats - b0 != 4 || done_cnt - d0 != 1 || exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL base_totals: got beats=%0d dones=%0d left=%0d want 4/1/0", beats - b0, done_cnt - d0, exp_data_q.size());
    end
  endtask

  task automatic test_rounding();
    logic [RES_W-1:0]  lanes [BATCH];
    logic [DATA_W-1:0] want  [5];
    int n;
    lanes = '{32'h0000_0018, 32'h0000_0017, 32'hFFFF_FFE8, 32'h7FFF_0000,
              32'h8001_0000, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0001_2345};
    want  = '{16'h0002, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    for (int i = 0; i < BATCH; i++) abuf_mem[8'h40][i*RES_W +: RES_W] = lanes[i];
    launch(8'h40, 1, 4);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_data[i*DATA_W +: DATA_W] !== want[i]) begin
        failures++;
        $display("FAIL round_lane%0d: got %h want %h", i, out_data[i*DATA_W +: DATA_W], want[i]);
      end
    end
    wait_done(30);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] want [4];
    want = '{8'd254, 8'd255, 8'd0, 8'd1};
    fill_random(254, 4);
    launch(254, 4, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (abuf_rd_addr !== want[c]) begin
        failures++; $display("FAIL wrap_addr%0d: got %0d want %0d", c, abuf_rd_addr, want[c]);
      end
    end
    wait_done(30);
  endtask

  task automatic test_backpressure();
    int d0, b0, h0, outstanding;
    fill_random(8'h20, 16);
    d0 = done_cnt; b0 = beats; h0 = hs_cnt;
    out_ready = 1'b1;
    launch(8'h20, 16, 1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    outstanding = (int'(abuf_rd_addr) - 32) - (hs_cnt - h0);
    checks++;
    if (outstanding != FIFO_D || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_outstanding: got %0d valid=%b want %0d/1", outstanding, out_valid, FIFO_D);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(80);
    checks++;
    if (beats - b0 != 16 || done_cnt - d0 != 1 || exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL bp_totals: got beats=%0d dones=%0d left=%0d want 16/1/0", beats - b0, done_cnt - d0, exp_data_q.size());
    end
  endtask

  task automatic test_len0_and_busy_start();
    int d0, b0;
    d0 = done_cnt; b0 = beats;
    launch(0, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (done !== (c == 1) || busy !== 1'b0) begin
        failures++;
        $display("FAIL len0_c%0d: got done=%b busy=%b want %b/0", c, done, busy, (c == 1));
      end
    end
    fill_random(8'h60, 8);
    d0 = done_cnt; b0 = beats;
    launch(8'h60, 8, 2);
    @(posedge clk); #1;
    base_addr = 8'h00; len = 9'd3; shift = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (beats - b0 != 8 || done_cnt - d0 != 1 || exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start: got beats=%0d dones=%0d left=%0d want 8/1/0", beats - b0, done_cnt - d0, exp_data_q.size());
    end
  endtask

  task automatic test_reset_midjob();
    int d0, b0, n;
    fill_random(8'h80, 10);
    fill_random(8'h90, 2);
    out_ready = 1'b1;
    b0 = beats;
    launch(8'h80, 10, 3);
    n = 0;
    while (beats - b0 < 3 && n < 40) begin @(negedge clk); #1; n++; end
    if (beats - b0 < 3) begin
      checks++; failures++; $display("FAIL rst_wait: got %0d beats want 3", beats - b0);
    end
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_immediate: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    exp_data_q.delete();
    exp_last_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_no_done: got dones=%0d busy=%b want 0/0", done_cnt - d0, busy);
    end
    b0 = beats;
    launch(8'h90, 2, 0);
    wait_done(30);
    checks++;
    if (beats - b0 != 2 || exp_data_q.size() != 0) begin
      failures++; $display("FAIL rst_rejob: got beats=%0d left=%0d want 2/0", beats - b0, exp_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_rounding();
    test_wrap();
    test_backpressure();
    test_len0_and_busy_start();
    test_reset_midjob();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_abuf_drain.md
Name: pe_abuf_drain

Overview:
- Reader side of the PE accumulation buffer. It sweeps a range of accum-buffer addresses through the PE read port (abuf_rd_addr/abuf_rd_data).
- Each BATCH×RES_W word is rescaled: arithmetic right shift with round-half-up, then signed saturation to DATA_W.
- Results stream out on a valid/ready interface toward the writeback/DDR path.
- Back-pressure is credit-controlled, so no read data is ever dropped.

Parameters:
- BATCH, 8, lanes per accum word.
- RES_W, 32, accumulator lane width, signed.
- DATA_W, 16, output lane width, signed.
- BUF_DEPTH, 256, accum-buffer depth.
- ADDR_W, bw(BUF_DEPTH), address width.
- RD_LAT, 2, cycles from abuf_rd_addr to valid abuf_rd_data. Must be ≥1.
- FIFO_D, RD_LAT+3, output FIFO depth in entries.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-low reset (asserted when 0).
- start, in, 1: one-cycle job launch; honoured only in IDLE.
- base_addr, in, ADDR_W: first accum address of the job.
- len, in, ADDR_W+1: number of words to drain, 0..BUF_DEPTH.
- shift, in, 5: right-shift amount, 0..RES_W-1.
- busy, out, 1: high from the cycle after an accepted start until the done pulse.
- done, out, 1: one-cycle pulse at job completion.
- abuf_rd_addr, out, ADDR_W: read address to the PE accum buffer.
- abuf_rd_data, in, BATCH*RES_W: read data, valid RD_LAT cycles after the address.
- out_data, out, BATCH*DATA_W: rescaled lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accept.
- out_last, out, 1: marks the final beat of the job.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, abuf_rd_addr=0. FSM→IDLE. FIFO emptied, credits reset to FIFO_D, read-valid pipe cleared.
- FSM IDLE:
  - start=1 and len>0: latch base_addr/len/shift, go to READ.
  - start=1 and len=0: done=1 next cycle, stay IDLE, no beats.
- FSM READ:
  - Issue one address per cycle while credit>0.
  - Address = base_addr + k mod BUF_DEPTH; wraps from BUF_DEPTH-1 to 0.
  - After len issues, go to FLUSH.
- FSM FLUSH:
  - Wait until all in-flight reads have been written to the FIFO and the FIFO is empty, with the last beat handshaken.
  - Then done=1 for one cycle, busy=0, go to IDLE.
- Credits:
  - Credit = FIFO_D − (FIFO occupancy + reads in flight).
  - Decrement on issue; increment on output handshake (out_valid & out_ready).
  - A simultaneous issue and handshake leaves credit unchanged.
  - Credit is never negative.
  - FIFO overflow is impossible by construction; verification asserts it.
- Read-valid tag: RD_LAT-deep shift register alongside the address. It carries a last flag set on the len-th issue.
- Rescale stage, one register, per lane:
  - t = (x >>> shift) + (shift>0 ? x[shift-1] : 0), computed in RES_W+1 bits.
  - Saturate t to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Output:
  - First-word-fall-through FIFO with registered outputs.
  - out_data/out_last stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - The start cycle is cycle 0. The first address is issued in cycle 1.
  - out_valid first rises in cycle RD_LAT+3.
  - With out_ready held at 1, throughput is 1 beat/cycle with no bubbles.
- out_last=1 only on beat len−1.
- start while busy is ignored: no parameter relatch, no effect.
- Changing shift mid-job has no effect; the latched value is used.
- When rst is asserted mid-job, all state clears immediately and no done pulse is issued. After release, the block is IDLE.

Test Plan:
1. Base case, full throughput.
   - Stimulus: base_addr=0x10, len=4, shift=0, out_ready=1. Buffer holds lane values 1..32 (word k lane i = 8k+i+1).
   - Response: 4 beats in consecutive cycles with lanes equal to the stored values, and out_last on the 4th beat.
   - Response: first out_valid in cycle 5 (RD_LAT=2); done one cycle after the last handshake.
2. Rounding and saturation with shift=4.
   - Lane values 0x18 → 2; 0x17 → 1; −0x18 → −1; 0x7FFF_0000 → 32767; −0x7FFF_0000 → −32768.
3. Address wrap.
   - Stimulus: base_addr=254, len=4.
   - Response: abuf_rd_addr sequence 254, 255, 0, 1; beats in that order.
4. Back-pressure.
   - Stimulus: len=16, out_ready toggling 1/0 each cycle, then held low for 20 cycles.
   - Response: issues stall once credit reaches 0, with at most FIFO_D outstanding.
   - Response: no beat lost or duplicated; all 16 beats arrive in order and done fires once.
5. len=0 and start while busy.
   - len=0 → done in cycle 1, zero beats, busy never asserted.
   - A second start during a len=8 job is ignored; exactly 8 beats are produced.
6. Reset mid-job.
   - Stimulus: assert rst low after 3 beats of a len=10 job.
   - Response: out_valid=0 and busy=0 immediately, no done pulse.
   - Response: a new len=2 job then completes normally.
